// File: rtl/mem_rw_pkg.sv
// Shared definitions for the byte-oriented memory read/write protocol
// (master and controller sides): field widths, FSM state encoding and
// a saturating down-counter helper.
package mem_rw_pkg;

  localparam int ADDR_W = 6;
  localparam int NUM_W  = 4;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Byte counters stick at zero instead of wrapping.
  function automatic logic [NUM_W-1:0] dec_sat(input logic [NUM_W-1:0] v);
    return (v == '0) ? v : v - NUM_W'(1);
  endfunction

endpackage

// File: rtl/mem_rw_hold.sv
// One-byte write hold register feeding the controller's write channel.
// Latency: a loaded byte is presented on data_o/valid_o the next cycle.
// Backpressure: a load and a consume in the same cycle refill the register,
//   so the caller may offer a new byte whenever the current one is consumed.
// Ports: clk_i/rst_i (sync, active-high), load_i + data_i (new byte),
//   consume_i (current byte taken), clear_i (drop content), data_o/valid_o.
module mem_rw_hold
  import mem_rw_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              consume_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      // Load wins over consume: the slot is refilled in the same cycle.
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (consume_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/mem_rw_master.sv
// Initiator engine: takes one read/write command, requests the controller,
//   waits for ack (with timeout), then streams write bytes or delivers read bytes.
// Latency: request from cycle after accept; data phase from cycle after ack;
//   o_done one cycle after the last byte, o_cmd_ready the cycle after that.
// Backpressure: cmd/src use valid-ready; read bytes pass through and are only
//   acknowledged (o_rd_done) when the sink is ready; 1 write byte/cycle max.
// Ports: i_cmd_* / o_cmd_ready command in; i_src_* / o_src_ready write bytes in;
//   o_snk_* / i_snk_ready read bytes out; o_done / o_err completion pulses;
//   o_wr_req, o_rd_req, o_addr, o_num_b, i_ack, o_wr_*, i_wr_done, i_rd_*,
//   o_rd_done towards mem_rw_controller.
module mem_rw_master
  import mem_rw_pkg::*;
#(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  // command
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [NUM_W-1:0]  i_cmd_num_b,
  // write byte source
  input  logic [DATA_W-1:0] i_src_data,
  input  logic              i_src_valid,
  output logic              o_src_ready,
  // read byte sink
  output logic [DATA_W-1:0] o_snk_data,
  output logic              o_snk_valid,
  input  logic              i_snk_ready,
  // status
  output logic              o_done,
  output logic              o_err,
  // controller side
  output logic              o_wr_req,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_addr,
  output logic [NUM_W-1:0]  o_num_b,
  input  logic              i_ack,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_wr_valid,
  input  logic              i_wr_done,
  input  logic [DATA_W-1:0] i_rd_data,
  input  logic              i_rd_valid,
  output logic              o_rd_done
);

  localparam int TMR_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(ACK_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_W-1:0]  num_b_q, num_b_d;
  logic              wr_req_q, wr_req_d;
  logic              rd_req_q, rd_req_d;
  logic              err_q, err_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [NUM_W-1:0]  load_left_q, load_left_d;   // bytes still to pull from the source
  logic [NUM_W-1:0]  done_left_q, done_left_d;   // bytes still to be completed

  logic              cmd_ready;
  logic              src_ready;
  logic              snk_valid;
  logic              rd_done;
  logic              hold_load;
  logic              hold_consume;
  logic              hold_clear;
  logic [DATA_W-1:0] hold_data;
  logic              hold_vld;

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    addr_d       = addr_q;
    num_b_d      = num_b_q;
    wr_req_d     = wr_req_q;
    rd_req_d     = rd_req_q;
    err_d        = 1'b0;
    timer_d      = timer_q;
    load_left_d  = load_left_q;
    done_left_d  = done_left_q;
    cmd_ready    = 1'b0;
    src_ready    = 1'b0;
    snk_valid    = 1'b0;
    rd_done      = 1'b0;
    hold_load    = 1'b0;
    hold_consume = 1'b0;
    hold_clear   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          write_d = i_cmd_write;
          addr_d  = i_cmd_addr;
          num_b_d = i_cmd_num_b;
          timer_d = '0;
          if (i_cmd_num_b == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_REQ;
            wr_req_d = i_cmd_write;
            rd_req_d = !i_cmd_write;
          end
        end
      end

      ST_REQ: begin
        // An ack in the last timer cycle still wins over the timeout.
        if (i_ack) begin
          wr_req_d    = 1'b0;
          rd_req_d    = 1'b0;
          load_left_d = num_b_q;
          done_left_d = num_b_q;
          state_d     = write_q ? ST_WDATA : ST_RDATA;
        end else if (timer_q == TMR_MAX) begin
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_WDATA: begin
        hold_consume = hold_vld && i_wr_done;
        src_ready    = (!hold_vld || i_wr_done) && (load_left_q != '0);
        hold_load    = src_ready && i_src_valid;
        if (hold_load) begin
          load_left_d = dec_sat(load_left_q);
        end
        if (hold_consume) begin
          done_left_d = dec_sat(done_left_q);
          if (done_left_q == NUM_W'(1)) begin
            hold_clear = 1'b1;
            state_d    = ST_DONE;
          end
        end
      end

      ST_RDATA: begin
        snk_valid = i_rd_valid;
        rd_done   = i_rd_valid && i_snk_ready;
        if (rd_done) begin
          done_left_d = dec_sat(done_left_q);
          if (done_left_q == NUM_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      num_b_q     <= '0;
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      err_q       <= 1'b0;
      timer_q     <= '0;
      load_left_q <= '0;
      done_left_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      num_b_q     <= num_b_d;
      wr_req_q    <= wr_req_d;
      rd_req_q    <= rd_req_d;
      err_q       <= err_d;
      timer_q     <= timer_d;
      load_left_q <= load_left_d;
      done_left_q <= done_left_d;
    end
  end

  mem_rw_hold u_hold (
    .clk_i     (i_clk),
    .rst_i     (i_reset),
    .load_i    (hold_load),
    .consume_i (hold_consume),
    .clear_i   (hold_clear),
    .data_i    (i_src_data),
    .data_o    (hold_data),
    .valid_o   (hold_vld)
  );

  // Handshake readies are forced low while reset is held so nothing is
  // accepted in a cycle whose state is about to be discarded.
  assign o_cmd_ready = cmd_ready && !i_reset;
  assign o_src_ready = src_ready && !i_reset;
  assign o_snk_data  = i_rd_data;
  assign o_snk_valid = snk_valid;
  assign o_rd_done   = rd_done;
  assign o_done      = (state_q == ST_DONE);
  assign o_err       = err_q;
  assign o_wr_req    = wr_req_q;
  assign o_rd_req    = rd_req_q;
  assign o_addr      = addr_q;
  assign o_num_b     = num_b_q;
  assign o_wr_data   = hold_data;
  assign o_wr_valid  = hold_vld;

endmodule

// File: tb/tb_mem_rw_master.sv
// Scoreboard bench for mem_rw_master with a small controller/source/sink model.
module tb_mem_rw_master;

  localparam logic [1:0] EV_WR = 2'd0, EV_RD = 2'd1, EV_DONE = 2'd2, EV_ERR = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [17:0] dat;   // {addr, num_b, byte}
  } ev_t;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_cmd_valid = 1'b0;
  logic       i_cmd_write = 1'b0;
  logic [5:0] i_cmd_addr = '0;
  logic [3:0] i_cmd_num_b = '0;
  logic [7:0] i_src_data = '0;
  logic       i_src_valid = 1'b0;
  logic       i_snk_ready = 1'b1;
  logic       i_ack = 1'b0;
  logic       i_wr_done = 1'b1;
  logic [7:0] i_rd_data = '0;
  logic       i_rd_valid = 1'b0;
  logic       o_cmd_ready, o_src_ready, o_snk_valid, o_done, o_err;
  logic       o_wr_req, o_rd_req, o_wr_valid, o_rd_done;
  logic [7:0] o_snk_data, o_wr_data;
  logic [5:0] o_addr;
  logic [3:0] o_num_b;

  mem_rw_master #(.ACK_TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_num_b(i_cmd_num_b),
    .i_src_data(i_src_data), .i_src_valid(i_src_valid), .o_src_ready(o_src_ready),
    .o_snk_data(o_snk_data), .o_snk_valid(o_snk_valid), .i_snk_ready(i_snk_ready),
    .o_done(o_done), .o_err(o_err),
    .o_wr_req(o_wr_req), .o_rd_req(o_rd_req), .o_addr(o_addr), .o_num_b(o_num_b),
    .i_ack(i_ack), .o_wr_data(o_wr_data), .o_wr_valid(o_wr_valid), .i_wr_done(i_wr_done),
    .i_rd_data(i_rd_data), .i_rd_valid(i_rd_valid), .o_rd_done(o_rd_done)
  );

  always #5 i_clk = ~i_clk;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  ev_t  exp_q[$];
  logic [7:0] src_q[$];
  logic [7:0] rd_q[$];
  int   wr_cycs[$];
  int   done_cycs[$];
  int   done_cnt = 0, err_cnt = 0;
  int   req_run = 0, req_run_last = 0;
  int   stall_cnt = 0;
  logic err_rdy = 1'b0;
  logic req_seen = 1'b0;
  logic overlap_seen = 1'b0;
  logic rd_done_bad = 1'b0;
  logic src_take, rd_take;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_ev(input logic [1:0] k, input logic [5:0] a, input logic [3:0] n,
                         input logic [7:0] b);
    exp_q.push_back({k, a, n, b});
  endtask

  task automatic sb_check(input logic [1:0] k, input logic [17:0] d);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL sb_unexpected: got kind %0d data %0h, expected nothing", k, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.dat !== d) begin
        miscompares++;
        $display("FAIL sb_event: got kind %0d data %0h, expected kind %0d data %0h",
                 k, d, e.kind, e.dat);
      end
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge, away from the active edge.
  initial forever begin
    @(negedge i_clk);
    if (!i_reset) begin
      if (o_wr_valid && i_wr_done) begin
        sb_check(EV_WR, {o_addr, o_num_b, o_wr_data});
        wr_cycs.push_back(cyc);
      end
      if (o_snk_valid && i_snk_ready) sb_check(EV_RD, {o_addr, o_num_b, o_snk_data});
      if (o_done) begin
        sb_check(EV_DONE, {o_addr, o_num_b, 8'h00});
        done_cycs.push_back(cyc);
        done_cnt++;
      end
      if (o_err) begin
        sb_check(EV_ERR, {o_addr, o_num_b, 8'h00});
        err_rdy = o_cmd_ready;
        err_cnt++;
      end
    end
    if (o_wr_req && o_rd_req) overlap_seen = 1'b1;
    if (o_wr_req || o_rd_req) req_seen = 1'b1;
    if (o_rd_done !== (o_snk_valid && i_snk_ready)) rd_done_bad = 1'b1;
    if (o_snk_valid && !i_snk_ready) stall_cnt++;
    if (o_wr_req) req_run++;
    else if (req_run != 0) begin
      req_run_last = req_run;
      req_run = 0;
    end
  end

  // Write-byte source: always offers the head of src_q.
  initial forever begin
    @(negedge i_clk);
    src_take = o_src_ready && i_src_valid;
    @(posedge i_clk);
    #1;
    if (src_take && src_q.size() > 0) void'(src_q.pop_front());
    i_src_valid = (src_q.size() > 0);
    i_src_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
  end

  // Controller read channel: holds each byte until o_rd_done.
  initial forever begin
    @(negedge i_clk);
    rd_take = o_rd_done;
    @(posedge i_clk);
    #1;
    if (rd_take && rd_q.size() > 0) void'(rd_q.pop_front());
    i_rd_valid = (rd_q.size() > 0);
    i_rd_data  = (rd_q.size() > 0) ? rd_q[0] : 8'h00;
  end

  task automatic send_cmd(input logic w, input logic [5:0] a, input logic [3:0] n,
                          output int acc_cyc);
    bit ok = 1'b0;
    acc_cyc = -1;
    i_cmd_valid = 1'b1; i_cmd_write = w; i_cmd_addr = a; i_cmd_num_b = n;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge i_clk);
      if (o_cmd_ready) begin ok = 1'b1; acc_cyc = cyc; end
      @(posedge i_clk);
      #1;
    end
    i_cmd_valid = 1'b0;
    if (!ok) check("cmd_accept_timeout", 0, 1);
  endtask

  task automatic do_ack(input int dly);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge i_clk);
      if (o_wr_req || o_rd_req) seen = 1'b1;
    end
    if (!seen) check("req_wait_timeout", 0, 1);
    else begin
      repeat (dly) @(posedge i_clk);
      #1 i_ack = 1'b1;
      @(posedge i_clk);
      #1 i_ack = 1'b0;
    end
  endtask

  task automatic wait_cnt(input string nm, input bit use_err, input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge i_clk);
      #1;
      if ((use_err ? err_cnt : done_cnt) >= target) ok = 1'b1;
    end
    if (!ok) check(nm, 0, 1);
  endtask

  initial begin
    int acc, acc2;

    // Reset state.
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_cmd_ready", o_cmd_ready, 0);
    check("reset_src_ready", o_src_ready, 0);
    check("reset_outputs", {o_wr_req, o_rd_req, o_wr_valid, o_wr_data, o_addr, o_num_b, o_done, o_err}, 0);
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    check("idle_cmd_ready", o_cmd_ready, 1);
    @(posedge i_clk);
    #1;

    // Write 3 bytes at addr 0, ack after 2 cycles, wr_done every cycle.
    src_q = '{8'h03, 8'h04, 8'h05};
    wr_cycs.delete(); done_cycs.delete();
    push_ev(EV_WR, 6'd0, 4'd3, 8'h03);
    push_ev(EV_WR, 6'd0, 4'd3, 8'h04);
    push_ev(EV_WR, 6'd0, 4'd3, 8'h05);
    push_ev(EV_DONE, 6'd0, 4'd3, 8'h00);
    fork
      send_cmd(1'b1, 6'd0, 4'd3, acc);
      do_ack(2);
    join
    wait_cnt("write_done_timeout", 1'b0, 1);
    check("write_bytes", wr_cycs.size(), 3);
    if (wr_cycs.size() == 3) begin
      check("write_back_to_back", wr_cycs[2] - wr_cycs[0], 2);
      if (done_cycs.size() > 0) check("write_done_latency", done_cycs[0] - wr_cycs[2], 1);
    end
    @(negedge i_clk);
    check("ready_after_done", o_cmd_ready, 1);
    @(posedge i_clk);
    #1;

    // Read 2 bytes at addr 10 with 3 stall cycles on the first byte.
    rd_q = '{8'hA5, 8'h5A};
    i_snk_ready = 1'b0;
    stall_cnt = 0;
    push_ev(EV_RD, 6'd10, 4'd2, 8'hA5);
    push_ev(EV_RD, 6'd10, 4'd2, 8'h5A);
    push_ev(EV_DONE, 6'd10, 4'd2, 8'h00);
    fork
      send_cmd(1'b0, 6'd10, 4'd2, acc);
      do_ack(1);
      begin
        for (int i = 0; i < 60 && stall_cnt < 3; i++) begin
          @(posedge i_clk);
          #1;
        end
        i_snk_ready = 1'b1;
      end
    join
    wait_cnt("read_done_timeout", 1'b0, 2);
    check("read_stall_cycles", stall_cnt, 3);
    check("rd_done_follows_ready", rd_done_bad, 0);

    // Ack timeout: request held exactly 8 cycles, then err with cmd_ready.
    push_ev(EV_ERR, 6'h3F, 4'd1, 8'h00);
    send_cmd(1'b1, 6'h3F, 4'd1, acc);
    wait_cnt("err_wait_timeout", 1'b1, 1);
    check("timeout_req_cycles", req_run_last, 8);
    check("err_with_cmd_ready", err_rdy, 1);

    // Zero length: no request, done one cycle after accept.
    req_seen = 1'b0;
    done_cycs.delete();
    push_ev(EV_DONE, 6'd9, 4'd0, 8'h00);
    send_cmd(1'b1, 6'd9, 4'd0, acc);
    wait_cnt("zero_done_timeout", 1'b0, 3);
    check("zero_no_req", req_seen, 0);
    if (done_cycs.size() > 0) check("zero_done_latency", done_cycs[0] - acc, 1);

    // Reset after the first of four write bytes.
    src_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    wr_cycs.delete();
    push_ev(EV_WR, 6'd5, 4'd4, 8'hB0);
    fork
      send_cmd(1'b1, 6'd5, 4'd4, acc);
      do_ack(1);
    join
    for (int i = 0; i < 40 && wr_cycs.size() == 0; i++) begin
      @(posedge i_clk);
      #1;
    end
    check("mid_write_first_byte", wr_cycs.size(), 1);
    i_reset = 1'b1;
    i_wr_done = 1'b0;
    src_q.delete();
    @(negedge i_clk);
    @(negedge i_clk);
    check("mid_reset_outputs", {o_wr_req, o_rd_req, o_wr_valid, o_wr_data, o_addr, o_num_b, o_done, o_err}, 0);
    check("mid_reset_readies", {o_cmd_ready, o_src_ready}, 0);
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    i_wr_done = 1'b1;
    src_q = '{8'h77};
    push_ev(EV_WR, 6'd7, 4'd1, 8'h77);
    push_ev(EV_DONE, 6'd7, 4'd1, 8'h00);
    fork
      send_cmd(1'b1, 6'd7, 4'd1, acc);
      do_ack(1);
    join
    wait_cnt("post_reset_done_timeout", 1'b0, 4);

    // Back-to-back: write 2 then read 1 with cmd_valid held.
    src_q = '{8'h11, 8'h22};
    rd_q = '{8'hC3};
    done_cycs.delete();
    push_ev(EV_WR, 6'd20, 4'd2, 8'h11);
    push_ev(EV_WR, 6'd20, 4'd2, 8'h22);
    push_ev(EV_DONE, 6'd20, 4'd2, 8'h00);
    push_ev(EV_RD, 6'd33, 4'd1, 8'hC3);
    push_ev(EV_DONE, 6'd33, 4'd1, 8'h00);
    fork
      begin
        send_cmd(1'b1, 6'd20, 4'd2, acc);
        send_cmd(1'b0, 6'd33, 4'd1, acc2);
      end
      begin
        do_ack(1);
        do_ack(1);
      end
    join
    wait_cnt("b2b_done_timeout", 1'b0, 6);
    if (done_cycs.size() > 0) check("b2b_accept_cycle", acc2 - done_cycs[0], 1);
    check("no_req_overlap", overlap_seen, 0);

    repeat (3) @(posedge i_clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "global timeout");
  end

endmodule
